// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants and types for the AXI3 read-side arbiter.
package axi_rd_arbiter_pkg;

   localparam logic [3:0] ID_INST = 4'd0;
   localparam logic [3:0] ID_DATA = 4'd1;

   localparam logic [2:0] AXSIZE_1B = 3'd0;
   localparam logic [2:0] AXSIZE_2B = 3'd1;
   localparam logic [2:0] AXSIZE_4B = 3'd2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } arb_state_e;

endpackage

// File: rtl/axi_rd_arbiter_outst.sv
// Saturating up/down in-flight read counter; one instance per AXI ID.
module rd_outst_counter #(
   parameter int MAX = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc_i,
   input  logic       dec_i,
   output logic [2:0] cnt_o,
   output logic       full_o,
   output logic       empty_o,
   output logic       underflow_o
);

   logic [2:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d       = cnt_q;
      underflow_o = 1'b0;
      if (inc_i && !dec_i) begin
         if (cnt_q != 3'(MAX)) cnt_d = cnt_q + 3'd1;
      end else if (dec_i && !inc_i) begin
         // A completion with nothing in flight is a stray beat: hold at 0 and flag it.
         if (cnt_q == 3'd0) underflow_o = 1'b1;
         else               cnt_d = cnt_q - 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= 3'd0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o   = cnt_q;
   assign full_o  = (cnt_q >= 3'(MAX));
   assign empty_o = (cnt_q == 3'd0);

endmodule

// File: rtl/axi_rd_arbiter.sv
// Schedules inst-fetch (ARID 0) and data-load (ARID 1) reads onto one AXI3 AR/R pair.
module axi_rd_arbiter
   import axi_rd_arbiter_pkg::*;
#(
   parameter int MAX_OUTST  = 2,
   parameter int STARVE_LIM = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req_valid,
   input  logic [31:0] inst_req_addr,
   output logic        inst_req_ready,
   output logic        inst_rsp_valid,
   output logic [31:0] inst_rsp_data,
   input  logic        inst_rsp_ready,
   input  logic        data_req_valid,
   input  logic [31:0] data_req_addr,
   input  logic [2:0]  data_req_size,
   output logic        data_req_ready,
   output logic        data_rsp_valid,
   output logic [31:0] data_rsp_data,
   input  logic        data_rsp_ready,
   input  logic        wr_pending,
   input  logic [31:0] wr_addr,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [2:0]  arsize,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic        err_bad_rid
);

   arb_state_e  state_q, state_d;
   logic [3:0]  arid_q, arid_d;
   logic [31:0] araddr_q, araddr_d;
   logic [2:0]  arsize_q, arsize_d;
   logic [7:0]  starve_q, starve_d;
   logic        err_q, err_d;

   logic [2:0]  inst_cnt, data_cnt;
   logic        inst_full, data_full, inst_empty, data_empty, inst_uf, data_uf;
   logic        hazard, inst_elig, data_elig, force_inst, grant_inst, grant_data;
   logic        ar_hs, inc_inst, inc_data, dec_inst, dec_data, rid_bad;
   logic        unused_ok;

   // Word-granular alias check against the single in-flight write.
   assign hazard     = wr_pending && (wr_addr[31:2] == data_req_addr[31:2]);
   assign inst_elig  = inst_req_valid && !inst_full;
   assign data_elig  = data_req_valid && !data_full && !hazard;
   assign force_inst = (starve_q == 8'(STARVE_LIM)) && inst_elig;
   assign grant_data = (state_q == ST_IDLE) && data_elig && !force_inst;
   assign grant_inst = (state_q == ST_IDLE) && inst_elig && !grant_data;

   assign inst_req_ready = grant_inst;
   assign data_req_ready = grant_data;

   always_comb begin
      state_d  = state_q;
      arid_d   = arid_q;
      araddr_d = araddr_q;
      arsize_d = arsize_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_data) begin
               arid_d   = ID_DATA;
               araddr_d = data_req_addr;
               arsize_d = data_req_size;
               state_d  = ST_ISSUE;
            end else if (grant_inst) begin
               arid_d   = ID_INST;
               araddr_d = inst_req_addr;
               arsize_d = AXSIZE_4B;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (arready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      starve_d = starve_q;
      if (grant_inst)
         starve_d = 8'd0;
      else if (grant_data && inst_req_valid && (starve_q < 8'(STARVE_LIM)))
         starve_d = starve_q + 8'd1;
   end

   always_comb begin
      inst_rsp_valid = 1'b0;
      data_rsp_valid = 1'b0;
      rready         = 1'b1;
      rid_bad        = 1'b0;
      if (rid == ID_INST) begin
         inst_rsp_valid = rvalid;
         rready         = inst_rsp_ready;
      end else if (rid == ID_DATA) begin
         data_rsp_valid = rvalid;
         rready         = data_rsp_ready;
      end else begin
         rid_bad = rvalid;
      end
   end

   assign inst_rsp_data = rdata;
   assign data_rsp_data = rdata;

   assign ar_hs    = (state_q == ST_ISSUE) && arready;
   assign inc_inst = ar_hs && (arid_q == ID_INST);
   assign inc_data = ar_hs && (arid_q == ID_DATA);
   assign dec_inst = rvalid && rready && rlast && (rid == ID_INST);
   assign dec_data = rvalid && rready && rlast && (rid == ID_DATA);
   assign err_d    = err_q || rid_bad || inst_uf || data_uf;

   rd_outst_counter #(.MAX(MAX_OUTST)) u_inst_cnt (
      .clk        (clk),
      .reset      (reset),
      .inc_i      (inc_inst),
      .dec_i      (dec_inst),
      .cnt_o      (inst_cnt),
      .full_o     (inst_full),
      .empty_o    (inst_empty),
      .underflow_o(inst_uf)
   );

   rd_outst_counter #(.MAX(MAX_OUTST)) u_data_cnt (
      .clk        (clk),
      .reset      (reset),
      .inc_i      (inc_data),
      .dec_i      (dec_data),
      .cnt_o      (data_cnt),
      .full_o     (data_full),
      .empty_o    (data_empty),
      .underflow_o(data_uf)
   );

   assign unused_ok = ^{inst_empty, data_empty, inst_cnt, data_cnt};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         arid_q   <= 4'd0;
         araddr_q <= 32'd0;
         arsize_q <= 3'd0;
         starve_q <= 8'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         arid_q   <= arid_d;
         araddr_q <= araddr_d;
         arsize_q <= arsize_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

   assign arvalid     = (state_q == ST_ISSUE);
   assign arid        = arid_q;
   assign araddr      = araddr_q;
   assign arsize      = arsize_q;
   assign err_bad_rid = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed scoreboard bench for axi_rd_arbiter with default parameters.
module tb_axi_rd_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        inst_req_valid = 1'b0;
   logic [31:0] inst_req_addr = '0;
   logic        inst_req_ready;
   logic        inst_rsp_valid;
   logic [31:0] inst_rsp_data;
   logic        inst_rsp_ready = 1'b1;
   logic        data_req_valid = 1'b0;
   logic [31:0] data_req_addr = '0;
   logic [2:0]  data_req_size = '0;
   logic        data_req_ready;
   logic        data_rsp_valid;
   logic [31:0] data_rsp_data;
   logic        data_rsp_ready = 1'b1;
   logic        wr_pending = 1'b0;
   logic [31:0] wr_addr = '0;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic        arvalid;
   logic        arready = 1'b0;
   logic [3:0]  rid = '0;
   logic [31:0] rdata = '0;
   logic        rlast = 1'b0;
   logic        rvalid = 1'b0;
   logic        rready;
   logic        err_bad_rid;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [2:0]  size;
   } ar_t;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] data;
   } r_t;

   ar_t ar_q[$];
   r_t  r_q[$];

   always #5 clk = ~clk;

   axi_rd_arbiter #(.MAX_OUTST(2), .STARVE_LIM(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .inst_req_valid(inst_req_valid),
      .inst_req_addr (inst_req_addr),
      .inst_req_ready(inst_req_ready),
      .inst_rsp_valid(inst_rsp_valid),
      .inst_rsp_data (inst_rsp_data),
      .inst_rsp_ready(inst_rsp_ready),
      .data_req_valid(data_req_valid),
      .data_req_addr (data_req_addr),
      .data_req_size (data_req_size),
      .data_req_ready(data_req_ready),
      .data_rsp_valid(data_rsp_valid),
      .data_rsp_data (data_rsp_data),
      .data_rsp_ready(data_rsp_ready),
      .wr_pending    (wr_pending),
      .wr_addr       (wr_addr),
      .arid          (arid),
      .araddr        (araddr),
      .arsize        (arsize),
      .arvalid       (arvalid),
      .arready       (arready),
      .rid           (rid),
      .rdata         (rdata),
      .rlast         (rlast),
      .rvalid        (rvalid),
      .rready        (rready),
      .err_bad_rid   (err_bad_rid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_ar(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] size);
      ar_t e;
      e.id = id; e.addr = addr; e.size = size;
      ar_q.push_back(e);
   endtask

   task automatic check_ar(input string tag);
      ar_t e;
      if (ar_q.size() == 0) begin
         chk({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
         e = ar_q.pop_front();
         chk({tag, "_arvalid"}, 32'(arvalid), 32'd1);
         chk({tag, "_arid"}, 32'(arid), 32'(e.id));
         chk({tag, "_araddr"}, araddr, e.addr);
         chk({tag, "_arsize"}, 32'(arsize), 32'(e.size));
      end
   endtask

   // Bounded wait for AR, compare against the scoreboard, then accept it.
   task automatic ar_accept(input string tag);
      int n = 0;
      while (!arvalid && n < 10) begin
         tick();
         n++;
      end
      if (!arvalid) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         check_ar(tag);
         arready = 1'b1;
         tick();
         arready = 1'b0;
      end
   endtask

   task automatic drive_r(input logic [3:0] id, input logic [31:0] d, input logic last);
      r_t e;
      rid = id; rdata = d; rlast = last; rvalid = 1'b1;
      e.id = id; e.data = d;
      r_q.push_back(e);
      #1;
   endtask

   task automatic check_r(input string tag);
      r_t e;
      if (r_q.size() == 0) begin
         chk({tag, "_rq_empty"}, 32'd0, 32'd1);
      end else begin
         e = r_q.pop_front();
         chk({tag, "_rready"}, 32'(rready), 32'd1);
         if (e.id == 4'd0) begin
            chk({tag, "_inst_vld"}, 32'(inst_rsp_valid), 32'd1);
            chk({tag, "_data_vld"}, 32'(data_rsp_valid), 32'd0);
            chk({tag, "_inst_data"}, inst_rsp_data, e.data);
         end else begin
            chk({tag, "_data_vld"}, 32'(data_rsp_valid), 32'd1);
            chk({tag, "_inst_vld"}, 32'(inst_rsp_valid), 32'd0);
            chk({tag, "_data_data"}, data_rsp_data, e.data);
         end
      end
   endtask

   task automatic r_beat(input string tag, input logic [3:0] id, input logic [31:0] d, input logic last);
      drive_r(id, d, last);
      check_r(tag);
      tick();
      rvalid = 1'b0;
      rlast  = 1'b0;
      #1;
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_arid", 32'(arid), 32'd0);
      chk("rst_araddr", araddr, 32'd0);
      chk("rst_arsize", 32'(arsize), 32'd0);
      chk("rst_err", 32'(err_bad_rid), 32'd0);
      chk("rst_inst_cnt", 32'(dut.inst_cnt), 32'd0);
      chk("rst_data_cnt", 32'(dut.data_cnt), 32'd0);
      chk("rst_starve", 32'(dut.starve_q), 32'd0);

      // Single fetch
      inst_req_valid = 1'b1; inst_req_addr = 32'h1c00_0000;
      #1;
      chk("t1_inst_ready", 32'(inst_req_ready), 32'd1);
      push_ar(4'd0, 32'h1c00_0000, 3'd2);
      tick();
      inst_req_valid = 1'b0;
      chk("t1_inst_ready_drop", 32'(inst_req_ready), 32'd0);
      ar_accept("t1_ar");
      chk("t1_inst_cnt1", 32'(dut.inst_cnt), 32'd1);
      chk("t1_arvalid_low", 32'(arvalid), 32'd0);
      r_beat("t1_r", 4'd0, 32'h02c0_0000, 1'b1);
      chk("t1_inst_cnt0", 32'(dut.inst_cnt), 32'd0);

      // Simultaneous requests: data first
      inst_req_valid = 1'b1; inst_req_addr = 32'h1c00_0004;
      data_req_valid = 1'b1; data_req_addr = 32'h0000_1000; data_req_size = 3'd2;
      #1;
      chk("t2_data_ready", 32'(data_req_ready), 32'd1);
      chk("t2_inst_wait", 32'(inst_req_ready), 32'd0);
      push_ar(4'd1, 32'h0000_1000, 3'd2);
      tick();
      data_req_valid = 1'b0;
      ar_accept("t2_ar_data");
      chk("t2_inst_ready", 32'(inst_req_ready), 32'd1);
      push_ar(4'd0, 32'h1c00_0004, 3'd2);
      tick();
      inst_req_valid = 1'b0;
      ar_accept("t2_ar_inst");
      chk("t2_inst_cnt", 32'(dut.inst_cnt), 32'd1);
      chk("t2_data_cnt", 32'(dut.data_cnt), 32'd1);
      chk("t2_starve", 32'(dut.starve_q), 32'd0);
      r_beat("t2_r_data", 4'd1, 32'hdada_0001, 1'b1);
      r_beat("t2_r_inst", 4'd0, 32'h1111_0004, 1'b1);
      chk("t2_cnts_zero", 32'({dut.inst_cnt, dut.data_cnt}), 32'd0);

      // Starvation: four data ARs then a forced inst AR
      inst_req_valid = 1'b1; inst_req_addr = 32'h1c00_0008;
      data_req_valid = 1'b1; data_req_addr = 32'h0000_3002; data_req_size = 3'd1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t3_data_ready%0d", i), 32'(data_req_ready), 32'd1);
         chk($sformatf("t3_inst_wait%0d", i), 32'(inst_req_ready), 32'd0);
         push_ar(4'd1, 32'h0000_3002, 3'd1);
         tick();
         check_ar($sformatf("t3_ar%0d", i));
         arready = 1'b1;
         // Return the previous data read in the same cycle as this AR handshake.
         if (i > 0) begin
            drive_r(4'd1, 32'hd000_0000 + 32'(i - 1), 1'b1);
            check_r($sformatf("t3_r%0d", i));
         end
         tick();
         arready = 1'b0;
         rvalid = 1'b0; rlast = 1'b0;
         #1;
         chk($sformatf("t3_data_cnt%0d", i), 32'(dut.data_cnt), 32'd1);
      end
      chk("t3_starve_full", 32'(dut.starve_q), 32'd4);
      chk("t3_inst_forced", 32'(inst_req_ready), 32'd1);
      chk("t3_data_held", 32'(data_req_ready), 32'd0);
      push_ar(4'd0, 32'h1c00_0008, 3'd2);
      tick();
      inst_req_valid = 1'b0; data_req_valid = 1'b0;
      chk("t3_starve_clr", 32'(dut.starve_q), 32'd0);
      ar_accept("t3_ar_inst");
      r_beat("t3_r_last_data", 4'd1, 32'hd000_0003, 1'b1);
      r_beat("t3_r_inst", 4'd0, 32'h1111_0008, 1'b1);
      chk("t3_cnts_zero", 32'({dut.inst_cnt, dut.data_cnt}), 32'd0);

      // Read-after-write hazard on the same word
      wr_pending = 1'b1; wr_addr = 32'h0000_2008;
      data_req_valid = 1'b1; data_req_addr = 32'h0000_200a; data_req_size = 3'd1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t4_blocked%0d", i), 32'(data_req_ready), 32'd0);
         chk($sformatf("t4_no_ar%0d", i), 32'(arvalid), 32'd0);
         tick();
      end
      wr_pending = 1'b0;
      #1;
      chk("t4_released", 32'(data_req_ready), 32'd1);
      push_ar(4'd1, 32'h0000_200a, 3'd1);
      tick();
      data_req_valid = 1'b0;
      ar_accept("t4_ar");
      r_beat("t4_r", 4'd1, 32'h0bad_f00d, 1'b1);

      // Outstanding limit
      for (int k = 0; k < 2; k++) begin
         inst_req_valid = 1'b1; inst_req_addr = 32'h1c00_0100 + 32'(4 * k);
         #1;
         chk($sformatf("t5_ready%0d", k), 32'(inst_req_ready), 32'd1);
         push_ar(4'd0, 32'h1c00_0100 + 32'(4 * k), 3'd2);
         tick();
         inst_req_valid = 1'b0;
         ar_accept($sformatf("t5_ar%0d", k));
      end
      chk("t5_cnt_full", 32'(dut.inst_cnt), 32'd2);
      inst_req_valid = 1'b1; inst_req_addr = 32'h1c00_0108;
      #1;
      chk("t5_held_a", 32'(inst_req_ready), 32'd0);
      tick();
      chk("t5_held_b", 32'(inst_req_ready), 32'd0);
      r_beat("t5_r_nonlast", 4'd0, 32'haaaa_0000, 1'b0);
      chk("t5_cnt_nonlast", 32'(dut.inst_cnt), 32'd2);
      chk("t5_held_c", 32'(inst_req_ready), 32'd0);
      r_beat("t5_r_last0", 4'd0, 32'haaaa_0001, 1'b1);
      chk("t5_cnt_rel", 32'(dut.inst_cnt), 32'd1);
      chk("t5_released", 32'(inst_req_ready), 32'd1);
      push_ar(4'd0, 32'h1c00_0108, 3'd2);
      tick();
      inst_req_valid = 1'b0;
      ar_accept("t5_ar2");
      r_beat("t5_r_last1", 4'd0, 32'haaaa_0002, 1'b1);
      r_beat("t5_r_last2", 4'd0, 32'haaaa_0003, 1'b1);
      chk("t5_cnt_zero", 32'(dut.inst_cnt), 32'd0);

      // Bad RID
      inst_rsp_ready = 1'b0; data_rsp_ready = 1'b0;
      rid = 4'd3; rdata = 32'h3333_3333; rlast = 1'b1; rvalid = 1'b1;
      #1;
      chk("t6_rready", 32'(rready), 32'd1);
      chk("t6_no_inst", 32'(inst_rsp_valid), 32'd0);
      chk("t6_no_data", 32'(data_rsp_valid), 32'd0);
      tick();
      rvalid = 1'b0; rlast = 1'b0;
      inst_rsp_ready = 1'b1; data_rsp_ready = 1'b1;
      chk("t6_err_set", 32'(err_bad_rid), 32'd1);
      tick();
      chk("t6_err_sticky", 32'(err_bad_rid), 32'd1);
      chk("t6_cnts", 32'({dut.inst_cnt, dut.data_cnt}), 32'd0);

      // Reset while an AR is in ISSUE
      inst_req_valid = 1'b1; inst_req_addr = 32'h1c00_0200;
      tick();
      chk("t7_issue", 32'(arvalid), 32'd1);
      reset = 1'b1; inst_req_valid = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      chk("t7_arvalid", 32'(arvalid), 32'd0);
      chk("t7_err", 32'(err_bad_rid), 32'd0);
      chk("t7_araddr", araddr, 32'd0);
      chk("t7_inst_cnt", 32'(dut.inst_cnt), 32'd0);

      // Stray completion with nothing in flight
      rid = 4'd0; rdata = 32'h5555_5555; rlast = 1'b1; rvalid = 1'b1;
      tick();
      rvalid = 1'b0; rlast = 1'b0;
      #1;
      chk("t8_err_stray", 32'(err_bad_rid), 32'd1);
      chk("t8_cnt_hold", 32'(dut.inst_cnt), 32'd0);

      chk("sb_ar_drained", 32'(ar_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
